// File: rtl/branch_predict_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// registered mispredict redirect and branch/mispredict statistics.
module branch_predict_btb #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  logic        flush_q, flush_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] branches_q, branches_d;
  logic [31:0] mispred_q, mispred_d;

  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             if_hit, upd_hit, mispredict;
  logic             unused_pc_bits;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];
  assign unused_pc_bits = ^if_pc[1:0];

  // Lookup reads the registered array, so a same-cycle update is not yet visible.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = (if_hit && ctr_q[if_idx][1]) ? target_q[if_idx] : 32'd0;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          target_d[upd_idx] = upd_target;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = 2'b10;
      end
    end
  end

  always_comb begin
    mispredict = upd_valid &&
                 ((upd_taken != upd_pred_taken) ||
                  (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
    flush_d    = mispredict;
    redirect_d = redirect_q;
    if (mispredict) redirect_d = upd_taken ? upd_target : (upd_pc + 32'd8);
    branches_d = branches_q + {31'd0, upd_valid};
    mispred_d  = mispred_q + {31'd0, mispredict};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
      flush_q    <= 1'b0;
      redirect_q <= 32'd0;
      branches_q <= 32'd0;
      mispred_q  <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      target_q   <= target_d;
      ctr_q      <= ctr_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      branches_q <= branches_d;
      mispred_q  <= mispred_d;
    end
  end

  assign flush            = flush_q;
  assign redirect_pc      = redirect_q;
  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispred_q;

endmodule
